cnt_sweep_ctrl: RTL and testbench
=================================

// Module: cnt_sweep_ctrl
// PURPOSE
//  Sequencer for univ_bin_counter. Drives syn_clr/load/en/up/d to run
//  programmed sweeps between lo and hi (up, down or bounce), repeated reps
//  passes, with start/busy/done handshake, pause and abort. Reads q back.
//  Sits between the control/config logic and one univ_bin_counter instance.
// PARAMETERS
//  N       4  counter width; must match the driven univ_bin_counter
//  REPS_W  4  width of the reps pass-count field
// PORTS
//  clk           in   1       system clock, rising edge
//  reset         in   1       synchronous, active-high
//  start         in   1       begin sweep; sampled only in IDLE
//  mode          in   2       00 up, 01 down, 10 bounce, 11 reserved (=up)
//  lo            in   N       lower sweep bound, latched on accepted start
//  hi            in   N       upper sweep bound, latched on accepted start
//  reps          in   REPS_W  passes to run; 0 = run until abort
//  pause         in   1       hold count while high; state unchanged
//  abort         in   1       stop sweep and clear counter
//  cnt_q         in   N       counter q
//  cnt_syn_clr   out  1       counter syn_clr
//  cnt_load      out  1       counter load
//  cnt_en        out  1       counter en
//  cnt_up        out  1       counter up
//  cnt_d         out  N       counter d
//  busy          out  1       high in LOAD, RUN, CLR
//  done          out  1       1-cycle pulse on normal completion
//  err           out  1       1-cycle pulse: start rejected because lo>hi
//  pass_cnt      out  REPS_W  completed passes in current sweep
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (incl. cnt_up, cnt_d, pass_cnt).
//  States: IDLE, LOAD, RUN, CLR, DONE. Moore outputs, except cnt_en (below).
//  IDLE: start=1 and lo<=hi -> latch lo/hi/mode/reps, pass_cnt<=0,
//    dir<=(mode!=01), ->LOAD. start=1 and lo>hi -> err=1 next cycle, stay IDLE.
//  LOAD: cnt_load=1, cnt_d = dir ? lo : hi. ->RUN. Counter q valid next cycle.
//  RUN: target = dir ? hi : lo; cnt_up=dir;
//    cnt_en = ~pause & (cnt_q!=target) (combinational, never steps past target).
//    cnt_q==target & ~pause = pass complete: pass_cnt+1.
//    If reps!=0 and pass_cnt+1==reps -> DONE.
//    Else up/down: ->LOAD (reload start bound). Else bounce: dir<=~dir, stay RUN.
//    Pass takes (hi-lo) en cycles + 1 detect cycle; lo==hi gives 1-cycle passes.
//    pass_cnt wraps at 2^REPS_W when reps=0.
//  DONE: done=1, busy=0, counter holds final q. ->IDLE.
//  abort: in LOAD/RUN -> CLR (priority over pass completion and pause).
//    In IDLE/DONE ignored.
//  CLR: cnt_syn_clr=1, cnt_en=0, cnt_load=0; pass_cnt<=0; no done. ->IDLE.
//  start while busy ignored. Config inputs ignored except at accepted start.
//  Reset mid-sweep: IDLE next edge, outputs 0; the counter is not cleared.
//  Exactly one of cnt_syn_clr/cnt_load/cnt_en high in any cycle, or none.
//  Start edge to done: reps*(hi-lo+2) + 1 cycles for up/down; bounce uses
//    1 + 1 + reps*(hi-lo) + reps cycles (one load only).
// TESTING
//  1 reset=1 2 cycles -> all outputs 0, busy=0; start ignored during reset.
//  2 N=4, mode=up, lo=3, hi=6, reps=2 -> load d=3; q 3,4,5,6 twice;
//    pass_cnt 1 then 2; done pulses once; final q=6.
//  3 mode=down, lo=2, hi=5, reps=1, pause=1 for 3 cycles mid-sweep ->
//    q 5,4,(hold x3),3,2; cnt_en=0 while paused; done after 3 extra cycles.
//  4 mode=bounce, lo=0, hi=15, reps=3 -> q 0..15..0..15, no wrap past
//    0/15, single cnt_load, cnt_up toggles at 15 and 0; done, q=15.
//  5 reps=0 up lo=1 hi=2, abort after 7 passes -> cnt_syn_clr 1 cycle,
//    q=0, pass_cnt=0, no done; start while busy had no effect.
//  6 lo=7, hi=4, start -> err 1 cycle, busy stays 0; then lo=hi=9,
//    reps=2 -> two 1-cycle passes, cnt_en never high, done.

Source files
------------

// File: rtl/cnt_sweep_ctrl.sv
// cnt_sweep_ctrl: sequencer for a univ_bin_counter. It runs up, down or
// bounce sweeps between a lower and upper bound for a programmed number of
// passes, with start/busy/done handshake, pause and abort. The counter value
// is read back on cnt_q_i so the sequencer never steps past a bound.
module cnt_sweep_ctrl #(
    parameter int N      = 4,
    parameter int REPS_W = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [N-1:0]      lo_i,
    input  logic [N-1:0]      hi_i,
    input  logic [REPS_W-1:0] reps_i,
    input  logic              pause_i,
    input  logic              abort_i,
    input  logic [N-1:0]      cnt_q_i,
    output logic              cnt_syn_clr_o,
    output logic              cnt_load_o,
    output logic              cnt_en_o,
    output logic              cnt_up_o,
    output logic [N-1:0]      cnt_d_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [REPS_W-1:0] pass_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CLR,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    state_t              state_q, state_d;
    logic [N-1:0]        lo_q, lo_d;
    logic [N-1:0]        hi_q, hi_d;
    logic [REPS_W-1:0]   reps_q, reps_d;
    logic [REPS_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic                dir_q, dir_d;      // 1 = counting up towards hi
    logic                bounce_q, bounce_d;
    logic                err_q, err_d;

    // Bound the counter is heading for in the current pass.
    logic [N-1:0]        target;
    logic                at_target;
    logic [REPS_W-1:0]   pass_inc;

    assign target    = dir_q ? hi_q : lo_q;
    assign at_target = (cnt_q_i == target);
    assign pass_inc  = pass_cnt_q + 1'b1;

    // State and configuration registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            lo_q       <= '0;
            hi_q       <= '0;
            reps_q     <= '0;
            pass_cnt_q <= '0;
            dir_q      <= 1'b0;
            bounce_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            reps_q     <= reps_d;
            pass_cnt_q <= pass_cnt_d;
            dir_q      <= dir_d;
            bounce_q   <= bounce_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: start acceptance, pass accounting and abort handling.
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        reps_d     = reps_q;
        pass_cnt_d = pass_cnt_q;
        dir_d      = dir_q;
        bounce_d   = bounce_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (lo_i <= hi_i) begin
                        lo_d       = lo_i;
                        hi_d       = hi_i;
                        reps_d     = reps_i;
                        pass_cnt_d = '0;
                        dir_d      = (mode_i != MODE_DOWN);
                        bounce_d   = (mode_i == MODE_BOUNCE);
                        state_d    = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                state_d = abort_i ? S_CLR : S_RUN;
            end
            S_RUN: begin
                if (abort_i) begin
                    // Abort wins over a pass completing in the same cycle.
                    state_d = S_CLR;
                end else if (!pause_i && at_target) begin
                    pass_cnt_d = pass_inc;
                    if ((reps_q != '0) && (pass_inc == reps_q)) begin
                        state_d = S_DONE;
                    end else if (bounce_q) begin
                        // Counter already sits on the new start bound.
                        dir_d = ~dir_q;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_CLR: begin
                pass_cnt_d = '0;
                state_d    = S_IDLE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Counter control outputs; only the enable looks at live inputs.
    always_comb begin
        cnt_syn_clr_o = 1'b0;
        cnt_load_o    = 1'b0;
        cnt_en_o      = 1'b0;
        cnt_up_o      = 1'b0;
        cnt_d_o       = '0;
        busy_o        = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            S_LOAD: begin
                busy_o     = 1'b1;
                cnt_load_o = 1'b1;
                cnt_up_o   = dir_q;
                cnt_d_o    = dir_q ? lo_q : hi_q;
            end
            S_RUN: begin
                busy_o   = 1'b1;
                cnt_up_o = dir_q;
                cnt_en_o = !pause_i && !at_target;
            end
            S_CLR: begin
                busy_o        = 1'b1;
                cnt_syn_clr_o = 1'b1;
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign err_o      = err_q;
    assign pass_cnt_o = pass_cnt_q;

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// Bench for cnt_sweep_ctrl: a behavioural counter closes the loop, a driver
// issues sweeps (directed and random) and queues the expected completion
// event, and a monitor pops and compares whenever done/err/syn_clr appears.
`timescale 1ns/1ps
module tb_cnt_sweep_ctrl;

    localparam int N  = 4;
    localparam int RW = 4;

    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;
    localparam int K_CLR  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [N-1:0]  lo, hi;
    logic [RW-1:0] reps;
    logic          pause, abort;
    logic [N-1:0]  cnt_q;
    logic          cnt_syn_clr, cnt_load, cnt_en, cnt_up;
    logic [N-1:0]  cnt_d;
    logic          busy, done, err;
    logic [RW-1:0] pass_cnt;

    always #5 clk = ~clk;

    cnt_sweep_ctrl #(.N(N), .REPS_W(RW)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .mode_i        (mode),
        .lo_i          (lo),
        .hi_i          (hi),
        .reps_i        (reps),
        .pause_i       (pause),
        .abort_i       (abort),
        .cnt_q_i       (cnt_q),
        .cnt_syn_clr_o (cnt_syn_clr),
        .cnt_load_o    (cnt_load),
        .cnt_en_o      (cnt_en),
        .cnt_up_o      (cnt_up),
        .cnt_d_o       (cnt_d),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .pass_cnt_o    (pass_cnt)
    );

    // Behavioural univ_bin_counter (no reset, so a controller reset leaves q).
    logic [N-1:0] q_model = '0;
    always @(posedge clk) begin
        if (cnt_syn_clr)  q_model <= '0;
        else if (cnt_load) q_model <= cnt_d;
        else if (cnt_en)   q_model <= cnt_up ? q_model + 1'b1 : q_model - 1'b1;
    end
    assign cnt_q = q_model;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int unsigned cyc;
        int          q;
        int          pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples just after each rising edge.
    bit   clr_pending = 0;
    exp_t mon_e;
    int   mon_kind;
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            check("ctrl_exclusive",
                  ((int'(cnt_syn_clr) + int'(cnt_load) + int'(cnt_en)) <= 1) ? 1 : 0, 1);
            if (pause) check("en_while_paused", cnt_en, 0);
            if (clr_pending) begin
                check("q_after_clr", q_model, 0);
                check("pass_after_clr", pass_cnt, 0);
                check("busy_after_clr", busy, 0);
                clr_pending = 0;
            end
            if (done || err || cnt_syn_clr) begin
                mon_kind = done ? K_DONE : (err ? K_ERR : K_CLR);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_event: got kind %0d, required none (cycle %0d)",
                             mon_kind, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_kind", mon_kind, mon_e.kind);
                    check("event_cycle", cyc, mon_e.cyc);
                    if (mon_kind == K_DONE) begin
                        check("done_q", q_model, mon_e.q);
                        check("done_pass_cnt", pass_cnt, mon_e.pc);
                        check("done_busy", busy, 0);
                    end else if (mon_kind == K_ERR) begin
                        check("err_busy", busy, 0);
                    end else begin
                        check("abort_pass_cnt", pass_cnt, mon_e.pc);
                        clr_pending = 1;
                    end
                    $display("txn kind=%0d cycle=%0d q=%0d pass_cnt=%0d",
                             mon_kind, cyc, q_model, pass_cnt);
                end
            end
        end
    end

    // Run one sweep. The schedule lists the cycles a sweep consists of:
    // 0 = load cycle, 1 = counting step, 2 = step that completes a pass.
    task automatic run_sweep(input int m, input int l, input int h, input int r,
                             input int pause_pct, input int pause_step, input int pause_len,
                             input int abort_pass, input int abort_off, input bit noise);
        int   sched[$];
        int   span, npass, plen, base, abort_idx, idx, passes, paused, forced, k, fq;
        bit   bnc;
        exp_t e;
        @(negedge clk);
        k     = cyc;
        start = 1'b1;
        mode  = 2'(m);
        lo    = N'(l);
        hi    = N'(h);
        reps  = RW'(r);
        pause = 1'b0;
        abort = 1'b0;
        if (l > h) begin
            e.kind = K_ERR; e.cyc = k + 1; e.q = 0; e.pc = 0;
            exp_q.push_back(e);
            @(negedge clk);
            start = 1'b0;
            return;
        end
        bnc   = (m == 2);
        span  = h - l;
        npass = (r != 0) ? r : abort_pass + 1;
        if (bnc) sched.push_back(0);
        for (int p = 0; p < npass; p++) begin
            if (!bnc) sched.push_back(0);
            for (int i = 0; i < span; i++) sched.push_back(1);
            sched.push_back(2);
        end
        abort_idx = -1;
        if (abort_pass >= 0) begin
            plen      = bnc ? span + 1 : span + 2;
            base      = bnc ? 1 + abort_pass * plen : abort_pass * plen;
            abort_idx = base + (abort_off % plen);
        end
        idx = 0; passes = 0; paused = 0; forced = pause_len;
        while (idx < sched.size()) begin
            @(negedge clk);
            start = noise && ($urandom_range(0, 3) == 0);
            if (noise) begin
                mode = 2'($urandom);
                lo   = N'($urandom);
                hi   = N'($urandom);
                reps = RW'($urandom);
            end
            if (idx == abort_idx) begin
                abort = 1'b1;
                pause = 1'($urandom);
                e.kind = K_CLR; e.cyc = cyc + 1; e.q = 0; e.pc = passes % (1 << RW);
                exp_q.push_back(e);
                @(negedge clk);
                abort = 1'b0; pause = 1'b0; start = 1'b0;
                @(negedge clk);
                return;
            end
            if (sched[idx] != 0 &&
                ((idx == pause_step && forced > 0) || $urandom_range(0, 99) < pause_pct)) begin
                pause = 1'b1;
                paused++;
                if (idx == pause_step && forced > 0) forced--;
            end else begin
                pause = 1'b0;
                if (sched[idx] == 2) passes++;
                idx++;
            end
        end
        if (bnc) fq = (r % 2 == 1) ? h : l;
        else     fq = (m == 1) ? l : h;
        e.kind = K_DONE;
        e.cyc  = k + (bnc ? 2 + r * span + r : r * (span + 2) + 1) + paused;
        e.q    = fq;
        e.pc   = r;
        exp_q.push_back(e);
        @(negedge clk);
        pause = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_syn_clr"}, cnt_syn_clr, 0);
        check({tag, "_load"}, cnt_load, 0);
        check({tag, "_en"}, cnt_en, 0);
        check({tag, "_up"}, cnt_up, 0);
        check({tag, "_d"}, cnt_d, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_pass_cnt"}, pass_cnt, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m, l, h, r, ap, ao;
        reset = 1'b1; start = 1'b1; mode = 2'b00; lo = 4'd1; hi = 4'd5;
        reps = 4'd1; pause = 1'b0; abort = 1'b0;
        // Reset held for two cycles with start high.
        repeat (2) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Directed sweeps.
        run_sweep(0, 3, 6, 2, 0, -1, 0, -1, 0, 1'b0);          // up, two passes
        run_sweep(1, 2, 5, 1, 0, 1, 3, -1, 0, 1'b0);           // down, pause x3
        run_sweep(2, 0, 15, 3, 0, -1, 0, -1, 0, 1'b0);         // bounce full range
        run_sweep(0, 1, 2, 0, 0, -1, 0, 7, 1, 1'b1);           // endless, abort
        run_sweep(0, 7, 4, 2, 0, -1, 0, -1, 0, 1'b0);          // lo > hi
        run_sweep(0, 9, 9, 2, 0, -1, 0, -1, 0, 1'b0);          // 1-cycle passes
        run_sweep(3, 4, 6, 1, 0, -1, 0, -1, 0, 1'b0);          // reserved mode = up
        run_sweep(1, 0, 3, 0, 0, -1, 0, 18, 2, 1'b1);          // pass_cnt wrap

        // Reset in the middle of a sweep: outputs drop, counter keeps its value.
        @(negedge clk);
        start = 1'b1; mode = 2'b00; lo = 4'd5; hi = 4'd12; reps = 4'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        check("mid_reset_q", q_model, 8);
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_q_hold", q_model, 8);

        // Random sweeps.
        for (int t = 0; t < 40; t++) begin
            m = $urandom_range(0, 3);
            l = $urandom_range(0, 15);
            h = $urandom_range(0, 15);
            if ($urandom_range(0, 3) != 0 && l > h) begin
                int tmp = l; l = h; h = tmp;
            end
            r  = $urandom_range(0, 5);
            ap = -1;
            ao = $urandom_range(0, 20);
            if (r == 0)                         ap = $urandom_range(0, 20);
            else if ($urandom_range(0, 4) == 0) ap = $urandom_range(0, r - 1);
            run_sweep(m, l, h, r, $urandom_range(0, 40), -1, 0, ap, ao, 1'b1);
        end

        repeat (5) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
